// File: rtl/hash_occurrence_counter_if.sv
// Init-stage bus between the DataFreqExt init pass and the occurrence counter.
// master = init stage (drives writes/CacheEnough), slave = counter (drives DataRequest).
interface hash_occurrence_counter_if #(
   parameter int LENGTH_ARRAY     = 100,
   parameter int DATA_INDEX_WIDTH = 32,
   parameter int BIT_ON_TAILS     = 7
);
   localparam int SAW = (LENGTH_ARRAY > 1) ? $clog2(LENGTH_ARRAY) : 1;

   logic                            DataRequest;
   logic                            CacheEnough;
   logic                            WrInitStreamData;
   logic [SAW-1:0]                  AddrInitStreamData;
   logic [DATA_INDEX_WIDTH-1:0]     InitStreamData;
   logic                            WrInitHash;
   logic [BIT_ON_TAILS:0]           AddrInitHashOccurr;
   logic [2*DATA_INDEX_WIDTH-1:0]   InitHashOccurr;

   modport master (
      input  DataRequest,
      output CacheEnough,
      output WrInitStreamData,
      output AddrInitStreamData,
      output InitStreamData,
      output WrInitHash,
      output AddrInitHashOccurr,
      output InitHashOccurr
   );

   modport slave (
      output DataRequest,
      input  CacheEnough,
      input  WrInitStreamData,
      input  AddrInitStreamData,
      input  InitStreamData,
      input  WrInitHash,
      input  AddrInitHashOccurr,
      input  InitHashOccurr
   );
endinterface

// File: rtl/hash_occurrence_counter.sv
// Counts stream value occurrences in a linear-probe hash table loaded from the init stage.
// Optional max-frequency tracking is enabled by defining DFE_MAXFREQ_EN.
module hash_occurrence_counter #(
   parameter int LENGTH_ARRAY     = 100,
   parameter int DATA_INDEX_WIDTH = 32,
   parameter int BIT_ON_TAILS     = 7
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            Start,
   hash_occurrence_counter_if.slave        init,
   input  logic [BIT_ON_TAILS-1:0]         RdAddr,
   output logic [2*DATA_INDEX_WIDTH-1:0]   RdData,
   output logic                            Busy,
   output logic                            Done,
   output logic                            Overflow,
   output logic [DATA_INDEX_WIDTH-1:0]     MaxKey,
   output logic [DATA_INDEX_WIDTH-1:0]     MaxCount
);
   localparam int DW  = DATA_INDEX_WIDTH;
   localparam int BT  = BIT_ON_TAILS;
   localparam int H   = 1 << BT;
   localparam int SAW = (LENGTH_ARRAY > 1) ? $clog2(LENGTH_ARRAY) : 1;
   localparam int CW  = $clog2(LENGTH_ARRAY + 1);
   localparam int HW  = BT + 1;

   localparam logic [CW-1:0] LEN_C   = CW'(LENGTH_ARRAY);
   localparam logic [CW-1:0] LAST_C  = CW'(LENGTH_ARRAY - 1);
   localparam logic [HW-1:0] H_C     = HW'(H);
   localparam logic [DW-1:0] CNT_MAX = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RD_STREAM,
      S_RD_HASH,
      S_UPDATE,
      S_DONE
   } state_t;

   state_t            state;
   logic              data_request;
   logic [CW-1:0]     swr_cnt;
   logic [HW-1:0]     hwr_cnt;
   logic [CW-1:0]     elem;
   logic [HW-1:0]     probes;
   logic [BT-1:0]     idx;
   logic [DW-1:0]     cur_data;
   logic [2*DW-1:0]   entry;

   logic [DW-1:0]     stream_mem [LENGTH_ARRAY];
   logic [2*DW-1:0]   table_mem  [H];

   logic [DW-1:0]     ent_key;
   logic [DW-1:0]     ent_cnt;
   logic [DW-1:0]     new_cnt;
   logic [DW-1:0]     stream_word;
   logic              is_empty;
   logic              is_hit;
   logic              last_probe;
   logic              elem_last;
   logic              stream_wr;
   logic              hash_init_wr;
   logic              upd_wr;
   logic              start_ok;
   logic              tbl_we;
   logic [BT-1:0]     tbl_wa;
   logic [2*DW-1:0]   tbl_wd;

   assign init.DataRequest = data_request;

   assign ent_key     = entry[2*DW-1:DW];
   assign ent_cnt     = entry[DW-1:0];
   assign is_empty    = (ent_cnt == '0);
   assign is_hit      = !is_empty && (ent_key == cur_data);
   assign last_probe  = ((probes + HW'(1)) == H_C);
   assign elem_last   = (elem == LAST_C);
   assign stream_word = stream_mem[elem[SAW-1:0]];
   assign start_ok    = Start && (state == S_IDLE || state == S_DONE);

   assign stream_wr = (state == S_LOAD) && init.WrInitStreamData
                      && (swr_cnt != LEN_C);
   assign hash_init_wr = (state == S_LOAD) && init.WrInitHash
                         && (hwr_cnt != H_C);
   assign upd_wr = (state == S_UPDATE) && (is_empty || is_hit);

   // Next count for the probed slot: new key starts at 1, hits saturate.
   always_comb begin
      new_cnt = ent_cnt;
      if (is_empty) begin
         new_cnt = DW'(1);
      end else if (ent_cnt != CNT_MAX) begin
         new_cnt = ent_cnt + DW'(1);
      end
   end

   // Table write port shared by the init load and the count update.
   always_comb begin
      tbl_we = 1'b0;
      tbl_wa = '0;
      tbl_wd = '0;
      if (hash_init_wr) begin
         tbl_we = 1'b1;
         tbl_wa = hwr_cnt[BT-1:0];
         tbl_wd = init.InitHashOccurr;
      end else if (upd_wr) begin
         tbl_we = 1'b1;
         tbl_wa = idx;
         tbl_wd = {cur_data, new_cnt};
      end
   end

   // Stream RAM, filled in arrival order from the internal counter.
   always_ff @(posedge clk) begin
      if (stream_wr) begin
         stream_mem[swr_cnt[SAW-1:0]] <= init.InitStreamData;
      end
   end

   // Hash table RAM.
   always_ff @(posedge clk) begin
      if (tbl_we) begin
         table_mem[tbl_wa] <= tbl_wd;
      end
   end

   // Result read port, one-cycle latency, free running.
   always_ff @(posedge clk) begin
      if (rst) begin
         RdData <= '0;
      end else begin
         RdData <= table_mem[RdAddr];
      end
   end

   // Control FSM: load, then per element read stream, probe, update.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         data_request <= 1'b0;
         Busy         <= 1'b0;
         Done         <= 1'b0;
         Overflow     <= 1'b0;
         swr_cnt      <= '0;
         hwr_cnt      <= '0;
         elem         <= '0;
         probes       <= '0;
         idx          <= '0;
         cur_data     <= '0;
         entry        <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (Start) begin
                  state        <= S_LOAD;
                  data_request <= 1'b1;
                  Busy         <= 1'b1;
                  Done         <= 1'b0;
                  Overflow     <= 1'b0;
                  swr_cnt      <= '0;
                  hwr_cnt      <= '0;
                  elem         <= '0;
               end
            end
            S_LOAD: begin
               if (stream_wr) begin
                  swr_cnt <= swr_cnt + CW'(1);
               end
               if (hash_init_wr) begin
                  hwr_cnt <= hwr_cnt + HW'(1);
               end
               if (init.CacheEnough && swr_cnt == LEN_C) begin
                  data_request <= 1'b0;
                  state        <= S_RD_STREAM;
                  elem         <= '0;
               end
            end
            S_RD_STREAM: begin
               cur_data <= stream_word;
               idx      <= BT'(stream_word);
               probes   <= '0;
               state    <= S_RD_HASH;
            end
            S_RD_HASH: begin
               entry <= table_mem[idx];
               state <= S_UPDATE;
            end
            S_UPDATE: begin
               if (is_empty || is_hit || last_probe) begin
                  if (!is_empty && !is_hit) begin
                     Overflow <= 1'b1;
                  end
                  elem <= elem + CW'(1);
                  if (elem_last) begin
                     state <= S_DONE;
                     Done  <= 1'b1;
                     Busy  <= 1'b0;
                  end else begin
                     state <= S_RD_STREAM;
                  end
               end else begin
                  probes <= probes + HW'(1);
                  idx    <= idx + BT'(1);
                  state  <= S_RD_HASH;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef DFE_MAXFREQ_EN
   // Most frequent key so far; strict compare keeps the earliest on ties.
   always_ff @(posedge clk) begin
      if (rst || start_ok) begin
         MaxKey   <= '0;
         MaxCount <= '0;
      end else if (upd_wr && new_cnt > MaxCount) begin
         MaxKey   <= cur_data;
         MaxCount <= new_cnt;
      end
   end
`else
   assign MaxKey   = '0;
   assign MaxCount = '0;
   logic unused_start_ok;
   assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_hash_occurrence_counter.sv
// Directed bench for hash_occurrence_counter: three instances (default,
// tiny table for overflow, 4-bit counts for saturation) fed by an init model.
module tb_hash_occurrence_counter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [2:0]  start = '0;
   logic [2:0]  s_wr  = '0;
   logic [2:0]  h_wr  = '0;
   logic [2:0]  ce    = '0;
   logic [31:0] s_data = '0;
   logic [6:0]  rd_addr = '0;

   int tests = 0;
   int fails = 0;

   logic [31:0] stim [0:127];
   logic [31:0] mk [0:127];
   logic [31:0] mc [0:127];
   logic        movf;
   logic [63:0] exp_q [$];

   wire  [2:0]  dr;
   wire  [2:0]  busy;
   wire  [2:0]  done;
   wire  [2:0]  ovf;
   logic [63:0] rd0, rd1;
   logic [7:0]  rd2;
   logic [31:0] mxk0, mxc0, mxk1, mxc1;
   logic [3:0]  mxk2, mxc2;

   hash_occurrence_counter_if #(.LENGTH_ARRAY(100), .DATA_INDEX_WIDTH(32),
      .BIT_ON_TAILS(7)) i0 ();
   hash_occurrence_counter_if #(.LENGTH_ARRAY(5), .DATA_INDEX_WIDTH(32),
      .BIT_ON_TAILS(2)) i1 ();
   hash_occurrence_counter_if #(.LENGTH_ARRAY(20), .DATA_INDEX_WIDTH(4),
      .BIT_ON_TAILS(7)) i2 ();

   assign i0.CacheEnough        = ce[0];
   assign i0.WrInitStreamData   = s_wr[0];
   assign i0.AddrInitStreamData = '0;
   assign i0.InitStreamData     = s_data;
   assign i0.WrInitHash         = h_wr[0];
   assign i0.AddrInitHashOccurr = '0;
   assign i0.InitHashOccurr     = '0;

   assign i1.CacheEnough        = ce[1];
   assign i1.WrInitStreamData   = s_wr[1];
   assign i1.AddrInitStreamData = '0;
   assign i1.InitStreamData     = s_data;
   assign i1.WrInitHash         = h_wr[1];
   assign i1.AddrInitHashOccurr = '0;
   assign i1.InitHashOccurr     = '0;

   assign i2.CacheEnough        = ce[2];
   assign i2.WrInitStreamData   = s_wr[2];
   assign i2.AddrInitStreamData = '0;
   assign i2.InitStreamData     = s_data[3:0];
   assign i2.WrInitHash         = h_wr[2];
   assign i2.AddrInitHashOccurr = '0;
   assign i2.InitHashOccurr     = '0;

   assign dr = {i2.DataRequest, i1.DataRequest, i0.DataRequest};

   hash_occurrence_counter #(.LENGTH_ARRAY(100), .DATA_INDEX_WIDTH(32),
      .BIT_ON_TAILS(7)) u0 (
      .clk(clk), .rst(rst), .Start(start[0]), .init(i0.slave),
      .RdAddr(rd_addr), .RdData(rd0), .Busy(busy[0]), .Done(done[0]),
      .Overflow(ovf[0]), .MaxKey(mxk0), .MaxCount(mxc0));

   hash_occurrence_counter #(.LENGTH_ARRAY(5), .DATA_INDEX_WIDTH(32),
      .BIT_ON_TAILS(2)) u1 (
      .clk(clk), .rst(rst), .Start(start[1]), .init(i1.slave),
      .RdAddr(rd_addr[1:0]), .RdData(rd1), .Busy(busy[1]), .Done(done[1]),
      .Overflow(ovf[1]), .MaxKey(mxk1), .MaxCount(mxc1));

   hash_occurrence_counter #(.LENGTH_ARRAY(20), .DATA_INDEX_WIDTH(4),
      .BIT_ON_TAILS(7)) u2 (
      .clk(clk), .rst(rst), .Start(start[2]), .init(i2.slave),
      .RdAddr(rd_addr), .RdData(rd2), .Busy(busy[2]), .Done(done[2]),
      .Overflow(ovf[2]), .MaxKey(mxk2), .MaxCount(mxc2));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [63:0] rd_of(input int n);
      case (n)
         0:       return rd0;
         1:       return rd1;
         default: return {56'd0, rd2};
      endcase
   endfunction

   // Reference linear-probe counting over stim[0:len-1].
   task automatic model(input int len, input int hd, input int dw);
      logic [31:0] m;
      logic [31:0] d;
      int          ix;
      bit          hit;
      m = (dw == 32) ? 32'hffff_ffff : ((32'd1 << dw) - 32'd1);
      for (int a = 0; a < 128; a++) begin
         mk[a] = '0;
         mc[a] = '0;
      end
      movf = 1'b0;
      for (int e = 0; e < len; e++) begin
         d   = stim[e] & m;
         ix  = int'(d) & (hd - 1);
         hit = 1'b0;
         for (int p = 0; p < hd && !hit; p++) begin
            if (mc[ix] == 0) begin
               mk[ix] = d;
               mc[ix] = 1;
               hit    = 1'b1;
            end else if (mk[ix] == d) begin
               if (mc[ix] < m) mc[ix] = mc[ix] + 1;
               hit = 1'b1;
            end else begin
               ix = (ix + 1) % hd;
            end
         end
         if (!hit) movf = 1'b1;
      end
   endtask

   task automatic read_one(input int n, input int a, input logic [63:0] e,
                           input string tag);
      logic [63:0] want;
      rd_addr = 7'(a);
      exp_q.push_back(e);
      step();
      want = exp_q.pop_front();
      chk(tag, rd_of(n), want);
   endtask

   task automatic check_table(input int n, input int hd, input int dw,
                              input string tag);
      logic [63:0] e;
      for (int a = 0; a < hd; a++) begin
         if (dw == 32) e = {mk[a], mc[a]};
         else          e = {56'd0, mk[a][3:0], mc[a][3:0]};
         read_one(n, a, e, $sformatf("%s[%0d]", tag, a));
      end
   endtask

   // Init-stage model: Start, stream+hash writes, CacheEnough, wait Done.
   task automatic do_pass(input int n, input int len, input int hd,
                          input int pulse_at);
      int nmax;
      int c;
      start[n] = 1'b1;
      step();
      start[n] = 1'b0;
      chk("dr_rise", 64'(dr[n]), 64'd1);
      chk("busy_load", 64'(busy[n]), 64'd1);
      chk("done_clr", 64'(done[n]), 64'd0);
      nmax = (len > hd) ? len : hd;
      for (int j = 0; j < nmax; j++) begin
         s_wr[n] = (j < len);
         s_data  = (j < len) ? stim[j] : 32'hdead_beef;
         h_wr[n] = (j < hd);
         step();
      end
      s_wr[n] = 1'b0;
      h_wr[n] = 1'b0;
      ce[n]   = 1'b1;
      chk("dr_hold", 64'(dr[n]), 64'd1);
      step();
      ce[n] = 1'b0;
      chk("dr_drop", 64'(dr[n]), 64'd0);
      c = 0;
      while (done[n] !== 1'b1 && c < 20000) begin
         if (c == pulse_at) start[n] = 1'b1;
         step();
         start[n] = 1'b0;
         if (c == pulse_at)
            chk("start_ignored", {62'd0, dr[n], busy[n]}, 64'd1);
         c++;
      end
      chk("done", 64'(done[n]), 64'd1);
      chk("busy_done", 64'(busy[n]), 64'd0);
   endtask

   function automatic logic [31:0] gen0(input int k);
      if (k % 5 == 0) return 32'(k % 20);
      if (k == 2)     return 32'd514;
      if (k >= 96)    return 32'd130;
      return 32'(k);
   endfunction

   task automatic load_gen0();
      for (int k = 0; k < 128; k++) stim[k] = (k < 100) ? gen0(k) : 32'd0;
   endtask

   task automatic check_s1(input string tag);
      model(100, 128, 32);
      chk({tag, "_ovf"}, 64'(ovf[0]), 64'(movf));
      chk({tag, "_ovf0"}, 64'(ovf[0]), 64'd0);
      read_one(0, 2,  {32'd514, 32'd1}, {tag, "_slot2"});
      read_one(0, 39, {32'd39,  32'd1}, {tag, "_slot39"});
      read_one(0, 0,  {32'd0,   32'd5}, {tag, "_slot0"});
      read_one(0, 20, {32'd130, 32'd4}, {tag, "_slot20"});
      read_one(0, 96, 64'd0,            {tag, "_slot96"});
      check_table(0, 128, 32, {tag, "_tbl"});
   endtask

   initial begin
      for (int k = 0; k < 128; k++) stim[k] = '0;
      rst = 1'b1;
      step();
      step();
      chk("rst_dr", {61'd0, dr}, 64'd0);
      chk("rst_busy", {61'd0, busy}, 64'd0);
      chk("rst_done", {61'd0, done}, 64'd0);
      chk("rst_ovf", {61'd0, ovf}, 64'd0);
      chk("rst_rd0", rd0, 64'd0);
      chk("rst_max", {mxk0, mxc0}, 64'd0);
      rst = 1'b0;
      step();

      // Default parameters with collisions and a long probe chain.
      load_gen0();
      do_pass(0, 100, 128, -1);
      check_s1("s1");

      // Tiny table: five distinct keys into four slots.
      stim[0] = 32'd0;  stim[1] = 32'd4;  stim[2] = 32'd8;
      stim[3] = 32'd12; stim[4] = 32'd16;
      do_pass(1, 5, 4, -1);
      model(5, 4, 32);
      chk("s3_ovf", 64'(ovf[1]), 64'd1);
      chk("s3_ovf_model", 64'(ovf[1]), 64'(movf));
      read_one(1, 3, {32'd12, 32'd1}, "s3_slot3");
      check_table(1, 4, 32, "s3_tbl");

      // Repeated key, Overflow must clear on the new pass.
      stim[0] = 32'd5; stim[1] = 32'd9; stim[2] = 32'd5;
      stim[3] = 32'd1; stim[4] = 32'd5;
      do_pass(1, 5, 4, -1);
      model(5, 4, 32);
      chk("s2_ovf", 64'(ovf[1]), 64'd0);
      read_one(1, 1, {32'd5, 32'd3}, "s2_slot1");
      read_one(1, 0, 64'd0, "s2_slot0");
      check_table(1, 4, 32, "s2_tbl");
`ifdef DFE_MAXFREQ_EN
      chk("s2_max", {mxk1, mxc1}, {32'd5, 32'd3});
`else
      chk("s2_max", {mxk1, mxc1}, 64'd0);
`endif

      // 4-bit counts saturate at 15.
      for (int k = 0; k < 20; k++) stim[k] = 32'd3;
      do_pass(2, 20, 128, -1);
      model(20, 128, 4);
      chk("s4_ovf", 64'(ovf[2]), 64'd0);
      read_one(2, 3, {56'd0, 4'd3, 4'd15}, "s4_sat");
      read_one(2, 4, 64'd0, "s4_slot4");
      check_table(2, 128, 4, "s4_tbl");

      // Reset in the middle of LOAD, then a clean rerun.
      for (int k = 0; k < 128; k++) stim[k] = 32'h5555_0000 + 32'(k);
      start[0] = 1'b1;
      step();
      start[0] = 1'b0;
      for (int j = 0; j < 10; j++) begin
         s_wr[0] = 1'b1;
         h_wr[0] = 1'b1;
         s_data  = stim[j];
         step();
      end
      s_wr[0] = 1'b0;
      h_wr[0] = 1'b0;
      rst = 1'b1;
      step();
      chk("s5_dr", 64'(dr[0]), 64'd0);
      chk("s5_busy", 64'(busy[0]), 64'd0);
      chk("s5_done", 64'(done[0]), 64'd0);
      rst = 1'b0;
      step();
      load_gen0();
      do_pass(0, 100, 128, -1);
      check_s1("s5");

      // Start while probing must not restart the pass.
      do_pass(0, 100, 128, 1);
      check_s1("s6");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
